ina219_regfile: RTL and testbench

//  Register bank and conversion engine behind the INA219 model's i2c_slave.

---
 rtl/ina219_regfile.sv | 232 +++++++++++++++++++++++
 tb/tb_ina219_regfile.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ina219_regfile.sv
// INA219 register bank and current/power conversion engine behind the I2C slave model.
// Optional: define INA_ALERT_EN to add the mask (ptr 06) / limit (ptr 07) registers and the alert output.
module ina219_regfile #(
    parameter logic [15:0] CONFIG_RST  = 16'h399F,
    parameter int          CAL_SHIFT   = 12,
    parameter int          PWR_DIVISOR = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_ptr,
    input  logic [15:0] wr_data,
    input  logic [7:0]  rd_ptr,
    output logic [15:0] rd_data,
    input  logic        rd_done,
    input  logic        sample_valid,
    input  logic [15:0] shunt_sample,
    input  logic [12:0] bus_sample,
    output logic        busy,
    output logic        alert
);

    typedef enum logic [2:0] {S_IDLE, S_CUR, S_PMUL, S_DIV, S_DONE} state_t;

    localparam logic signed [32:0] CUR_MAX  = 33'sd32767;
    localparam logic signed [32:0] CUR_MIN  = -33'sd32768;
    localparam logic [13:0]        DIVISOR  = 14'(PWR_DIVISOR);
    localparam logic [4:0]         DIV_LAST = 5'd28;

    state_t      state, next_state;

    logic [15:0] config_reg;
    logic [15:0] shunt_reg;
    logic [12:0] bus_v_reg;
    logic        cnvr;
    logic        ovf_flag;
    logic [15:0] power_reg;
    logic [15:0] current_reg;
    logic [15:1] cal_reg;

    logic [15:0] sh_shunt;
    logic [12:0] sh_bus;
    logic [15:0] cur_q;
    logic        cur_ovf_q;
    logic [28:0] div_m;
    logic [28:0] div_q;
    logic [12:0] div_rem;
    logic [4:0]  div_cnt;

    logic               soft_rst;
    logic               accept;
    logic signed [32:0] prod;
    logic signed [32:0] cur_full;
    logic [15:0]        cur_sat;
    logic               cur_ovf;
    logic [16:0]        cur_mag;
    logic [28:0]        mul_res;
    logic [13:0]        rem_shift;
    logic               rem_ge;
    logic [12:0]        rem_next;
    logic               q_ovf;
    logic [15:0]        power_new;

    // Modes 000 and 100 are the power-down modes, i.e. both low mode bits clear.
    assign soft_rst = wr_en && (wr_ptr == 8'h00) && wr_data[15];
    assign accept   = (state == S_IDLE) && sample_valid && (config_reg[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_CUR;
            S_CUR:   next_state = S_PMUL;
            S_PMUL:  next_state = S_DIV;
            S_DIV:   if (div_cnt == 5'd0) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (soft_rst) next_state = S_IDLE;
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // Cal is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        prod     = $signed(33'($signed(sh_shunt))) * $signed(33'({1'b0, cal_reg, 1'b0}));
        cur_full = prod >>> CAL_SHIFT;
        cur_sat  = cur_full[15:0];
        cur_ovf  = 1'b0;
        if (cur_full > CUR_MAX) begin
            cur_sat = 16'h7FFF;
            cur_ovf = 1'b1;
        end else if (cur_full < CUR_MIN) begin
            cur_sat = 16'h8000;
            cur_ovf = 1'b1;
        end
        cur_mag   = cur_q[15] ? (17'd0 - {1'b1, cur_q}) : {1'b0, cur_q};
        mul_res   = {12'd0, cur_mag} * {16'd0, sh_bus};
        rem_shift = {div_rem, div_m[28]};
        rem_ge    = (rem_shift >= DIVISOR);
        rem_next  = rem_ge ? 13'(rem_shift - DIVISOR) : rem_shift[12:0];
        q_ovf     = |div_q[28:16];
        power_new = q_ovf ? 16'hFFFF : div_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_shunt  <= '0;
            sh_bus    <= '0;
            cur_q     <= '0;
            cur_ovf_q <= 1'b0;
            div_m     <= '0;
            div_q     <= '0;
            div_rem   <= '0;
            div_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sh_shunt <= shunt_sample;
                        sh_bus   <= bus_sample;
                    end
                end
                S_CUR: begin
                    cur_q     <= cur_sat;
                    cur_ovf_q <= cur_ovf;
                end
                S_PMUL: begin
                    div_m   <= mul_res;
                    div_q   <= '0;
                    div_rem <= '0;
                    div_cnt <= DIV_LAST;
                end
                S_DIV: begin
                    div_m   <= {div_m[27:0], 1'b0};
                    div_q   <= {div_q[27:0], rem_ge};
                    div_rem <= rem_next;
                    div_cnt <= div_cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    // A DONE commit setting CNVR wins over any clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            config_reg  <= CONFIG_RST;
            shunt_reg   <= '0;
            bus_v_reg   <= '0;
            cnvr        <= 1'b0;
            ovf_flag    <= 1'b0;
            power_reg   <= '0;
            current_reg <= '0;
            cal_reg     <= '0;
        end else begin
            if (wr_en && (wr_ptr == 8'h00)) config_reg <= {1'b0, wr_data[14:0]};
            if (wr_en && (wr_ptr == 8'h05)) cal_reg <= wr_data[15:1];
            if (state == S_DONE) begin
                shunt_reg   <= sh_shunt;
                bus_v_reg   <= sh_bus;
                current_reg <= cur_q;
                power_reg   <= power_new;
                ovf_flag    <= cur_ovf_q | q_ovf;
                cnvr        <= 1'b1;
            end else if ((wr_en && (wr_ptr == 8'h00)) || (rd_done && (rd_ptr == 8'h03))) begin
                cnvr <= 1'b0;
            end
        end
    end

`ifdef INA_ALERT_EN
    logic [15:0] mask_reg;
    logic [15:0] limit_reg;
    logic        alert_reg;
    logic        alert_hit;

    always_comb begin
        alert_hit = (mask_reg[15] && ($signed(sh_shunt) > $signed(limit_reg))) ||
                    (mask_reg[14] && (sh_bus > limit_reg[12:0])) ||
                    (mask_reg[13] && (power_new > limit_reg));
    end

    // With latching enabled the alert only drops once the mask register has been read out.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            mask_reg  <= '0;
            limit_reg <= '0;
            alert_reg <= 1'b0;
        end else begin
            if (wr_en && (wr_ptr == 8'h06)) mask_reg <= wr_data;
            if (wr_en && (wr_ptr == 8'h07)) limit_reg <= wr_data;
            if (state == S_DONE) begin
                alert_reg <= mask_reg[0] ? (alert_reg | alert_hit) : alert_hit;
            end else if (rd_done && (rd_ptr == 8'h06) && mask_reg[0]) begin
                alert_reg <= 1'b0;
            end
        end
    end

    assign alert = alert_reg;
`else
    assign alert = 1'b0;
`endif

    always_comb begin
        rd_data = 16'h0000;
        case (rd_ptr)
            8'h00:   rd_data = config_reg;
            8'h01:   rd_data = shunt_reg;
            8'h02:   rd_data = {bus_v_reg, 1'b0, cnvr, ovf_flag};
            8'h03:   rd_data = power_reg;
            8'h04:   rd_data = current_reg;
            8'h05:   rd_data = {cal_reg, 1'b0};
`ifdef INA_ALERT_EN
            8'h06:   rd_data = mask_reg;
            8'h07:   rd_data = limit_reg;
`endif
            default: rd_data = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_ina219_regfile.sv
// Self-checking bench for ina219_regfile: directed register/conversion cases plus random traffic
// compared every cycle against an arithmetic model. Alert checks are compiled when INA_ALERT_EN is defined.
module tb_ina219_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_ptr;
    logic [15:0] wr_data;
    logic [7:0]  rd_ptr;
    logic [15:0] rd_data;
    logic        rd_done;
    logic        sample_valid;
    logic [15:0] shunt_sample;
    logic [12:0] bus_sample;
    logic        busy;
    logic        alert;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    ina219_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_ptr       (wr_ptr),
        .wr_data      (wr_data),
        .rd_ptr       (rd_ptr),
        .rd_data      (rd_data),
        .rd_done      (rd_done),
        .sample_valid (sample_valid),
        .shunt_sample (shunt_sample),
        .bus_sample   (bus_sample),
        .busy         (busy),
        .alert        (alert)
    );

    always #5 clk = ~clk;

    // Reference state: register contents plus the sample in flight and its age in clocks.
    logic [15:0] m_config, m_shunt, m_power, m_current, m_cal, m_mask, m_limit;
    logic [12:0] m_busv;
    logic        m_cnvr, m_ovf, m_alert;
    int          m_age;
    logic [15:0] m_sh, m_cal_used;
    logic [12:0] m_bus_s;

    function automatic void model_reset();
        m_config  = 16'h399F;
        m_shunt   = 16'h0;
        m_busv    = 13'h0;
        m_power   = 16'h0;
        m_current = 16'h0;
        m_cal     = 16'h0;
        m_mask    = 16'h0;
        m_limit   = 16'h0;
        m_cnvr    = 1'b0;
        m_ovf     = 1'b0;
        m_alert   = 1'b0;
        m_age     = -1;
    endfunction

    function automatic logic [15:0] model_read(input logic [7:0] p);
        case (p)
            8'h00:   return m_config;
            8'h01:   return m_shunt;
            8'h02:   return {m_busv, 1'b0, m_cnvr, m_ovf};
            8'h03:   return m_power;
            8'h04:   return m_current;
            8'h05:   return m_cal;
`ifdef INA_ALERT_EN
            8'h06:   return m_mask;
            8'h07:   return m_limit;
`endif
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin : ref_model
        longint cur, pw;
        bit     ovf, hit, commit;
        if (rst || (wr_en && wr_ptr == 8'h00 && wr_data[15])) begin
            model_reset();
        end else begin
            commit = (m_age == 31);
            if (commit) begin
                cur = (longint'($signed(m_sh)) * longint'(m_cal_used)) >>> 12;
                ovf = 1'b0;
                if (cur > 32767) begin
                    cur = 32767;
                    ovf = 1'b1;
                end else if (cur < -32768) begin
                    cur = -32768;
                    ovf = 1'b1;
                end
                pw = ((cur < 0) ? -cur : cur) * longint'(m_bus_s) / 5000;
                if (pw > 65535) begin
                    pw  = 65535;
                    ovf = 1'b1;
                end
                hit = (m_mask[15] && ($signed(m_sh) > $signed(m_limit))) ||
                      (m_mask[14] && (m_bus_s > m_limit[12:0])) ||
                      (m_mask[13] && (16'(pw) > m_limit));
                m_shunt   = m_sh;
                m_busv    = m_bus_s;
                m_current = 16'(cur);
                m_power   = 16'(pw);
                m_ovf     = ovf;
                m_cnvr    = 1'b1;
`ifdef INA_ALERT_EN
                m_alert   = m_mask[0] ? (m_alert | hit) : hit;
`endif
            end else begin
                if ((wr_en && wr_ptr == 8'h00) || (rd_done && rd_ptr == 8'h03)) m_cnvr = 1'b0;
                if (rd_done && rd_ptr == 8'h06 && m_mask[0]) m_alert = 1'b0;
            end
            if (m_age == 0) m_cal_used = m_cal;
            if (commit) begin
                m_age = -1;
            end else if (m_age >= 0) begin
                m_age++;
            end else if (sample_valid && m_config[1:0] != 2'b00) begin
                m_age   = 0;
                m_sh    = shunt_sample;
                m_bus_s = bus_sample;
            end
            if (wr_en && wr_ptr == 8'h00) m_config = {1'b0, wr_data[14:0]};
            if (wr_en && wr_ptr == 8'h05) m_cal = {wr_data[15:1], 1'b0};
`ifdef INA_ALERT_EN
            if (wr_en && wr_ptr == 8'h06) m_mask = wr_data;
            if (wr_en && wr_ptr == 8'h07) m_limit = wr_data;
`endif
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%04h expected=0x%04h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            checkOutput($sformatf("rd_data ptr %02h", rd_ptr), rd_data, model_read(rd_ptr));
            checkOutput("busy", {15'd0, busy}, {15'd0, (m_age >= 0)});
            checkOutput("alert", {15'd0, alert}, {15'd0, m_alert});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input bit sv, input logic [15:0] sh, input logic [12:0] bv,
                                 input bit we, input logic [7:0] wp, input logic [15:0] wd,
                                 input bit rdd);
        sample_valid = sv;
        shunt_sample = sh;
        bus_sample   = bv;
        wr_en        = we;
        wr_ptr       = wp;
        wr_data      = wd;
        rd_done      = rdd;
        tick();
        sample_valid = 1'b0;
        wr_en        = 1'b0;
        rd_done      = 1'b0;
    endtask

    task automatic writeReg(input logic [7:0] p, input logic [15:0] d);
        applyStimulus(1'b0, 16'h0, 13'h0, 1'b1, p, d, 1'b0);
    endtask

    task automatic sample(input logic [15:0] sh, input logic [12:0] bv);
        applyStimulus(1'b1, sh, bv, 1'b0, 8'h00, 16'h0, 1'b0);
    endtask

    task automatic expectReg(input string name, input logic [7:0] p, input logic [15:0] exp);
        rd_ptr = p;
        #1;
        checkOutput(name, rd_data, exp);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        wr_en        = 1'b0;
        wr_ptr       = 8'h00;
        wr_data      = 16'h0;
        rd_ptr       = 8'h00;
        rd_done      = 1'b0;
        sample_valid = 1'b0;
        shunt_sample = 16'h0;
        bus_sample   = 13'h0;
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;

        expectReg("reset config", 8'h00, 16'h399F);
        for (int p = 1; p <= 5; p++) expectReg("reset reg", 8'(p), 16'h0000);
        checkOutput("reset busy", {15'd0, busy}, 16'h0000);

        writeReg(8'h05, 16'h1000);
        sample(16'h0100, 13'd3000);
        idle(31);
        checkOutput("busy before done", {15'd0, busy}, 16'h0001);
        idle(1);
        checkOutput("busy after done", {15'd0, busy}, 16'h0000);
        expectReg("basic current", 8'h04, 16'h0100);
        expectReg("basic bus", 8'h02, 16'h5DC2);
        expectReg("basic power", 8'h03, 16'h0099);
        expectReg("basic shunt", 8'h01, 16'h0100);

        sample(16'hFF00, 13'd3000);
        idle(32);
        expectReg("neg current", 8'h04, 16'hFF00);
        expectReg("neg power", 8'h03, 16'h0099);
        expectReg("neg bus", 8'h02, 16'h5DC2);

        writeReg(8'h05, 16'hFFFE);
        sample(16'h7FFF, 13'd3000);
        idle(32);
        expectReg("sat current", 8'h04, 16'h7FFF);
        expectReg("sat bus ovf", 8'h02, 16'h5DC3);
        expectReg("sat power", 8'h03, 16'h4CCC);

        sample(16'h8000, 13'd8191);
        idle(32);
        expectReg("min current", 8'h04, 16'h8000);
        expectReg("min power", 8'h03, 16'hD1B0);
        expectReg("min bus", 8'h02, 16'hFFFB);

        writeReg(8'h05, 16'h1001);
        expectReg("cal bit0", 8'h05, 16'h1000);

        sample(16'h0100, 13'd3000);
        idle(9);
        applyStimulus(1'b1, 16'h7FFF, 13'd100, 1'b0, 8'h00, 16'h0, 1'b0);
        idle(22);
        expectReg("drop current", 8'h04, 16'h0100);
        expectReg("drop power", 8'h03, 16'h0099);
        expectReg("drop bus", 8'h02, 16'h5DC2);
        rd_ptr = 8'h03;
        applyStimulus(1'b0, 16'h0, 13'h0, 1'b0, 8'h00, 16'h0, 1'b1);
        expectReg("cnvr cleared", 8'h02, 16'h5DC0);

        writeReg(8'h05, 16'h0000);
        sample(16'h7FFF, 13'd8191);
        idle(32);
        expectReg("cal0 current", 8'h04, 16'h0000);
        expectReg("cal0 power", 8'h03, 16'h0000);
        expectReg("cal0 bus", 8'h02, 16'hFFFA);

        writeReg(8'h00, 16'h0004);
        expectReg("pd config", 8'h00, 16'h0004);
        sample(16'h0100, 13'd3000);
        checkOutput("pd busy", {15'd0, busy}, 16'h0000);
        idle(33);
        expectReg("pd bus", 8'h02, 16'hFFF8);
        writeReg(8'h00, 16'h399F);

        writeReg(8'h05, 16'h1000);
        sample(16'h0100, 13'd3000);
        idle(14);
        writeReg(8'h00, 16'h8000);
        checkOutput("abort busy", {15'd0, busy}, 16'h0000);
        expectReg("abort config", 8'h00, 16'h399F);
        for (int p = 1; p <= 5; p++) expectReg("abort reg", 8'(p), 16'h0000);
        idle(40);
        expectReg("abort cnvr", 8'h02, 16'h0000);

        writeReg(8'h06, 16'h1234);
        expectReg("unmapped 20", 8'h20, 16'h0000);
`ifdef INA_ALERT_EN
        expectReg("mask readback", 8'h06, 16'h1234);
        writeReg(8'h05, 16'h1000);
        writeReg(8'h06, 16'h8001);
        writeReg(8'h07, 16'h0050);
        sample(16'h0100, 13'd3000);
        idle(32);
        checkOutput("alert set", {15'd0, alert}, 16'h0001);
        idle(5);
        checkOutput("alert held", {15'd0, alert}, 16'h0001);
        rd_ptr = 8'h06;
        applyStimulus(1'b0, 16'h0, 13'h0, 1'b0, 8'h00, 16'h0, 1'b1);
        checkOutput("alert cleared", {15'd0, alert}, 16'h0000);
`else
        expectReg("unmapped 06", 8'h06, 16'h0000);
        checkOutput("alert tied", {15'd0, alert}, 16'h0000);
`endif

        for (int i = 0; i < 2500; i++) begin
            logic [7:0]  wp;
            logic [15:0] wd;
            logic [15:0] sh;
            case ($urandom_range(0, 7))
                0:       wp = 8'h00;
                1, 2, 3: wp = 8'h05;
                4:       wp = 8'h06;
                5:       wp = 8'h07;
                6:       wp = 8'($urandom_range(1, 4));
                default: wp = 8'($urandom_range(8, 255));
            endcase
            if (wp == 8'h00) wd = {($urandom_range(0, 29) == 0), 15'($urandom)};
            else             wd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            sh = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 600));
            rd_ptr = 8'($urandom_range(0, 9));
            applyStimulus($urandom_range(0, 99) < 15, sh, 13'($urandom), $urandom_range(0, 9) == 0,
                          wp, wd, $urandom_range(0, 9) == 0);
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
